// File: rtl/wb_writer.sv
// Write-back initiator: buffers execute results and drains them into the register-file write
// and branch ports, publishing a per-register pending mask. Define WB_FWD_EN for forwarding lookups.
module wb_writer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 4,
    parameter int unsigned DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          res_valid,
    output logic          res_ready,
    input  logic [AW-1:0] res_addr,
    input  logic [DW-1:0] res_data,
    input  logic          res_br,
    input  logic          res_link,
    input  logic [DW-1:0] res_ldata,
    output logic          rf_we,
    output logic [AW-1:0] rf_wa,
    output logic [DW-1:0] rf_wd,
    output logic          rf_ib,
    output logic [DW-1:0] rf_bv,
    output logic          rf_bl,
    output logic [15:0]   pend,
    output logic          idle
`ifdef WB_FWD_EN
    ,
    input  logic [AW-1:0] fq_a0,
    input  logic [AW-1:0] fq_a1,
    output logic          fq_hit0,
    output logic          fq_hit1,
    output logic [DW-1:0] fq_d0,
    output logic [DW-1:0] fq_d1
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [AW-1:0] R_LR = AW'(14);
    localparam logic [AW-1:0] R_PC = AW'(15);

    typedef struct packed {
        logic          br;
        logic          link;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [DW-1:0] ldata;
    } entry_t;

    typedef enum logic {
        S_IDLE,
        S_LINK
    } state_t;

    entry_t         mem [DEPTH];
    entry_t         in_e;
    entry_t         head;
    entry_t         ord [DEPTH];
    logic [DEPTH-1:0] ord_v;
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic [CW-1:0]  count;
    state_t         state;
    state_t         state_n;
    logic           push;
    logic           pop;
    logic           link_done;

    logic           we_n;
    logic [AW-1:0]  wa_n;
    logic [DW-1:0]  wd_n;
    logic           ib_n;
    logic [DW-1:0]  bv_n;
    logic           bl_n;

    assign res_ready = !rst && (count < FULL);
    assign push      = res_valid && res_ready;
    assign head      = mem[rd_ptr];
    assign idle      = (count == '0) && (state == S_IDLE);
    assign link_done = (state == S_LINK);

    // Link only has meaning on branches, so it is normalised at entry.
    assign in_e = '{br: res_br, link: res_br & res_link, addr: res_addr,
                    data: res_data, ldata: res_ldata};

    // FIFO storage
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_e;
        end
    end

    // Entries viewed oldest-first, index 0 being the head
    always_comb begin
        ord_v = '0;
        for (int unsigned a = 0; a < DEPTH; a++) begin
            ord[a]   = mem[rd_ptr + PW'(a)];
            ord_v[a] = (CW'(a) < count);
        end
    end

    // Pending mask; the head's r14 write no longer counts once issued
    always_comb begin
        pend = '0;
        for (int unsigned a = 0; a < DEPTH; a++) begin
            if (ord_v[a]) begin
                if (ord[a].br) begin
                    pend[15] = 1'b1;
                    if (ord[a].link && !((a == 0) && link_done)) begin
                        pend[14] = 1'b1;
                    end
                end else begin
                    pend[ord[a].addr] = 1'b1;
                end
            end
        end
    end

    // Drain FSM: one register-file action per cycle
    always_comb begin
        state_n = state;
        pop     = 1'b0;
        we_n    = 1'b0;
        wa_n    = '0;
        wd_n    = '0;
        ib_n    = 1'b0;
        bv_n    = '0;
        bl_n    = 1'b0;
        case (state)
            S_IDLE: begin
                if (count != '0) begin
                    if (!head.br) begin
                        we_n = 1'b1;
                        wa_n = head.addr;
                        wd_n = head.data;
                        pop  = 1'b1;
                    end else if (!head.link) begin
                        ib_n = 1'b1;
                        bv_n = head.data;
                        pop  = 1'b1;
                    end else begin
                        we_n    = 1'b1;
                        wa_n    = R_LR;
                        wd_n    = head.ldata;
                        state_n = S_LINK;
                    end
                end
            end
            S_LINK: begin
                ib_n    = 1'b1;
                bv_n    = head.data;
                bl_n    = 1'b1;
                pop     = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State, pointers and registered strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            rf_we  <= 1'b0;
            rf_wa  <= '0;
            rf_wd  <= '0;
            rf_ib  <= 1'b0;
            rf_bv  <= '0;
            rf_bl  <= 1'b0;
        end else begin
            state <= state_n;
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
            rf_we <= we_n;
            rf_wa <= wa_n;
            rf_wd <= wd_n;
            rf_ib <= ib_n;
            rf_bv <= bv_n;
            rf_bl <= bl_n;
        end
    end

`ifdef WB_FWD_EN
    logic [1:0][AW-1:0] fq_a;
    logic [1:0][DW-1:0] fq_d;
    logic [1:0]         fq_hit;

    assign fq_a[0] = fq_a0;
    assign fq_a[1] = fq_a1;

    // Youngest match wins; the PC is never forwarded
    always_comb begin
        fq_hit = '0;
        fq_d   = '0;
        for (int unsigned p = 0; p < 2; p++) begin
            for (int unsigned a = 0; a < DEPTH; a++) begin
                if (ord_v[a] && (fq_a[p] != R_PC)) begin
                    if (!ord[a].br && (ord[a].addr == fq_a[p])) begin
                        fq_hit[p] = 1'b1;
                        fq_d[p]   = ord[a].data;
                    end else if (ord[a].br && ord[a].link && (fq_a[p] == R_LR)
                                 && !((a == 0) && link_done)) begin
                        fq_hit[p] = 1'b1;
                        fq_d[p]   = ord[a].ldata;
                    end
                end
            end
        end
    end

    assign fq_hit0 = fq_hit[0];
    assign fq_hit1 = fq_hit[1];
    assign fq_d0   = fq_d[0];
    assign fq_d1   = fq_d[1];
`endif

endmodule

// File: tb/tb_wb_writer.sv
// Scoreboard bench for wb_writer: pushes directed results, a forked monitor checks every strobe.
module tb_wb_writer;

    logic        clk;
    logic        rst;
    logic        res_valid;
    logic        res_ready;
    logic [3:0]  res_addr;
    logic [31:0] res_data;
    logic        res_br;
    logic        res_link;
    logic [31:0] res_ldata;
    logic        rf_we;
    logic [3:0]  rf_wa;
    logic [31:0] rf_wd;
    logic        rf_ib;
    logic [31:0] rf_bv;
    logic        rf_bl;
    logic [15:0] pend;
    logic        idle;
`ifdef WB_FWD_EN
    logic [3:0]  fq_a0;
    logic [3:0]  fq_a1;
    logic        fq_hit0;
    logic        fq_hit1;
    logic [31:0] fq_d0;
    logic [31:0] fq_d1;
`endif

    wb_writer #(.DEPTH(4), .AW(4), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .res_valid(res_valid), .res_ready(res_ready), .res_addr(res_addr),
        .res_data(res_data), .res_br(res_br), .res_link(res_link), .res_ldata(res_ldata),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .rf_ib(rf_ib), .rf_bv(rf_bv), .rf_bl(rf_bl),
        .pend(pend), .idle(idle)
`ifdef WB_FWD_EN
        ,
        .fq_a0(fq_a0), .fq_a1(fq_a1), .fq_hit0(fq_hit0), .fq_hit1(fq_hit1),
        .fq_d0(fq_d0), .fq_d1(fq_d1)
`endif
    );

    typedef struct packed {
        logic        we;
        logic        ib;
        logic        bl;
        logic [3:0]  wa;
        logic [31:0] d;
    } act_t;

    act_t exp_q[$];
    int   errors  = 0;
    int   checks  = 0;
    int   strobes = 0;
    int   stalls  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic act_t mk(input logic we, input logic ib, input logic bl,
                                input logic [3:0] wa, input logic [31:0] d);
        act_t r;
        r.we = we; r.ib = ib; r.bl = bl; r.wa = wa; r.d = d;
        return r;
    endfunction

    // Every strobe must match the oldest outstanding expectation
    task automatic monitor();
        act_t g;
        act_t e;
        forever begin
            @(negedge clk);
            if (rf_we === 1'b1 || rf_ib === 1'b1) begin
                strobes++;
                g = mk(rf_we, rf_ib, rf_bl, rf_we ? rf_wa : 4'h0, rf_we ? rf_wd : rf_bv);
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", 64'(g), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("strobe", 64'(g), 64'(e));
                end
            end
        end
    endtask

    // Offer one result; returns at posedge+1 after the accepting edge
    task automatic push(input logic br, input logic link, input logic [3:0] addr,
                        input logic [31:0] data, input logic [31:0] ldata);
        bit acc;
        bit rdy;
        acc = 1'b0;
        res_valid = 1'b1; res_br = br; res_link = link;
        res_addr = addr; res_data = data; res_ldata = ldata;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk);
            rdy = res_ready;
            if (!rdy) stalls++;
            @(posedge clk);
            #1;
            acc = rdy;
        end
        res_valid = 1'b0;
        chk("accept", 64'(acc), 64'(1));
        if (acc) begin
            if (br && link) begin
                exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 4'd14, ldata));
                exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 4'd0, data));
            end else if (br) begin
                exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 4'd0, data));
            end else begin
                exp_q.push_back(mk(1'b1, 1'b0, 1'b0, addr, data));
            end
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (idle === 1'b1 && exp_q.size() == 0) break;
        end
        chk("drain_idle", 64'(idle), 64'(1));
        chk("drain_queue", 64'(exp_q.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int s0;
        rst = 1'b1; res_valid = 1'b0; res_addr = '0; res_data = '0;
        res_br = 1'b0; res_link = 1'b0; res_ldata = '0;
`ifdef WB_FWD_EN
        fq_a0 = '0; fq_a1 = '0;
`endif
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_strobes", 64'({rf_we, rf_ib, rf_bl}), 64'(0));
        chk("reset_wd", 64'(rf_wd), 64'(0));
        chk("reset_bv", 64'(rf_bv), 64'(0));
        chk("reset_pend", 64'(pend), 64'(0));
        chk("reset_idle", 64'(idle), 64'(1));
        chk("reset_ready", 64'(res_ready), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 64'(res_ready), 64'(1));
        @(posedge clk);
        #1;

        // Single plain write
        push(1'b0, 1'b0, 4'd3, 32'hDEADBEEF, 32'h0);
        chk("t1_pend", 64'(pend), 64'(16'h0008));
        chk("t1_busy", 64'(idle), 64'(0));
        @(posedge clk); #1;
        chk("t1_we", 64'(rf_we), 64'(1));
        chk("t1_pend_drop", 64'(pend), 64'(0));
        chk("t1_idle", 64'(idle), 64'(1));
        @(posedge clk); #1;
        chk("t1_we_once", 64'(rf_we), 64'(0));

        // Branch with link: r14 write then branch
        push(1'b1, 1'b1, 4'd0, 32'h100, 32'h44);
        chk("t2_pend", 64'(pend), 64'(16'hC000));
        @(posedge clk); #1;
        chk("t2_we", 64'({rf_we, rf_ib}), 64'(2'b10));
        chk("t2_pend_lr", 64'(pend), 64'(16'h8000));
        @(posedge clk); #1;
        chk("t2_ib", 64'({rf_we, rf_ib, rf_bl}), 64'(3'b011));
        chk("t2_pend_pc", 64'(pend), 64'(16'h0000));
        chk("t2_idle", 64'(idle), 64'(1));

        // r15 write, plain branch, link flag without branch
        push(1'b0, 1'b0, 4'd15, 32'hA5A5, 32'h0);
        chk("t3_pend_r15", 64'(pend), 64'(16'h8000));
        push(1'b1, 1'b0, 4'd0, 32'h1234, 32'h0);
        chk("t3_pend_br", 64'(pend), 64'(16'h8000));
        push(1'b0, 1'b1, 4'd7, 32'h77, 32'h99);
        chk("t3_pend_r7", 64'(pend), 64'(16'h0080));
        wait_idle();

        // Back-pressure with a burst of branch-links
        stalls = 0;
        for (int i = 0; i < 8; i++) begin
            push(1'b1, 1'b1, 4'd0, 32'h200 + 32'(i), 32'h300 + 32'(i));
        end
        chk("t4_backpressure", 64'(stalls != 0), 64'(1));
        wait_idle();

        // Same-register ordering and pending
        push(1'b0, 1'b0, 4'd2, 32'd1, 32'h0);
        chk("t5_pend_a", 64'(pend), 64'(16'h0004));
        push(1'b0, 1'b0, 4'd2, 32'd2, 32'h0);
        chk("t5_pend_b", 64'(pend), 64'(16'h0004));
        push(1'b0, 1'b0, 4'd5, 32'd7, 32'h0);
        chk("t5_pend_c", 64'(pend), 64'(16'h0020));
        wait_idle();

`ifdef WB_FWD_EN
        // Forwarding lookups
        fq_a0 = 4'd4; fq_a1 = 4'd14;
        push(1'b1, 1'b1, 4'd0, 32'h600, 32'h6EE);
        chk("fwd_lr_hit", 64'({fq_hit1, fq_d1}), 64'({1'b1, 32'h6EE}));
        chk("fwd_r4_miss", 64'(fq_hit0), 64'(0));
        push(1'b1, 1'b1, 4'd0, 32'h700, 32'h7EE);
        chk("fwd_lr_second", 64'({fq_hit1, fq_d1}), 64'({1'b1, 32'h7EE}));
        push(1'b0, 1'b0, 4'd4, 32'h11, 32'h0);
        push(1'b0, 1'b0, 4'd4, 32'h22, 32'h0);
        chk("fwd_youngest", 64'({fq_hit0, fq_d0}), 64'({1'b1, 32'h22}));
        chk("fwd_lr_issued", 64'(fq_hit1), 64'(0));
        push(1'b0, 1'b0, 4'd15, 32'h99, 32'h0);
        fq_a1 = 4'd15;
        #1;
        chk("fwd_pc_never", 64'(fq_hit1), 64'(0));
        chk("fwd_pend", 64'(pend), 64'(16'h8010));
        wait_idle();
        chk("fwd_empty", 64'(fq_hit0), 64'(0));
`endif

        // Reset while in the link phase with two entries buffered
        push(1'b1, 1'b1, 4'd0, 32'h500, 32'h501);
        push(1'b1, 1'b1, 4'd0, 32'h510, 32'h511);
        rst = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        s0 = strobes;
        chk("rst_mid_strobes", 64'({rf_we, rf_ib, rf_bl}), 64'(0));
        chk("rst_mid_pend", 64'(pend), 64'(0));
        chk("rst_mid_idle", 64'(idle), 64'(1));
        chk("rst_mid_ready", 64'(res_ready), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_no_strobe", 64'(strobes - s0), 64'(0));
        chk("rst_ready", 64'(res_ready), 64'(1));
        push(1'b0, 1'b0, 4'd9, 32'hCAFE, 32'h0);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
